// File: rtl/sync_mul_pkg.sv
// Shared types and limits for the valid/ready multicycle multiplier wrapper.
package sync_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int SETTLE_MAX = 255;

endpackage

// File: rtl/sync_mul_core.sv
// Combinational (WIDTH+1)x(WIDTH+1) signed multiplier; its paths are a declared
// multicycle path of SETTLE_CYCLES, so the wrapper must hold the operands stable.
module sync_mul_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic               i_signed,
    output logic [2*WIDTH-1:0] o_p
);

    logic signed [WIDTH:0]     w_a_ext;
    logic signed [WIDTH:0]     w_b_ext;
    logic signed [2*WIDTH-1:0] w_prod;

    // One extra bit makes both modes a single signed multiply; only the low
    // 2*WIDTH bits are kept, which is exact for every operand pair.
    assign w_a_ext = {i_signed & i_a[WIDTH-1], i_a};
    assign w_b_ext = {i_signed & i_b[WIDTH-1], i_b};
    assign w_prod  = (2*WIDTH)'(w_a_ext) * (2*WIDTH)'(w_b_ext);
    assign o_p     = w_prod;

endmodule

// File: rtl/sync_mul_pipe.sv
// Single-clock valid/ready wrapper: captures operands, lets the core settle for
// SETTLE_CYCLES cycles, then holds the product until the sink takes it.
module sync_mul_pipe
    import sync_mul_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_c,
    output logic               busy
);

    localparam int               CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > SETTLE_MAX) begin : g_bad_settle
            $error("sync_mul_pipe: SETTLE_CYCLES out of range 1..255");
        end
    endgenerate

    state_t               r_state;
    logic [WIDTH-1:0]     r_op_a;
    logic [WIDTH-1:0]     r_op_b;
    logic                 r_op_signed;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_out_c;
    logic                 r_out_valid;
    logic [2*WIDTH-1:0]   w_prod;
    logic                 w_accept;

    sync_mul_core #(.WIDTH(WIDTH)) u_core (
        .i_a      (r_op_a),
        .i_b      (r_op_b),
        .i_signed (r_op_signed),
        .o_p      (w_prod)
    );

    // out_ready feeds in_ready combinationally so a HOLD slot can be reused at once.
    assign in_ready  = (r_state == IDLE) | ((r_state == HOLD) & out_ready);
    assign w_accept  = in_valid & in_ready;
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign out_c     = r_out_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_signed <= 1'b0;
            r_cnt       <= '0;
            r_out_c     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op_a      <= in_a;
                r_op_b      <= in_b;
                r_op_signed <= in_signed;
                r_cnt       <= CNT_LOAD;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) r_state <= WAIT;
                end
                WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_out_c     <= w_prod;
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= w_accept ? WAIT : IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_mul_pipe.sv
// Bench for sync_mul_pipe: a SETTLE=6 and a SETTLE=1 instance, a timing-level
// reference model checked every cycle, and directed vectors with literal results.
module tb_sync_mul_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv[2], ord[2], isg[2];
    logic [31:0] ia[2], ib[2];
    logic        ir[2], ov[2], bsy[2];
    logic [63:0] oc[2];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit started = 1'b0;

    // reference model: transaction pending / product visible, due edge number
    bit          m_have[2], m_val[2];
    int          m_due[2];
    logic [63:0] m_prod[2], m_c[2];

    logic [63:0] q_val[$];
    int          q_cyc[$];

    always #5 clk = ~clk;

    sync_mul_pipe #(.WIDTH(32), .SETTLE_CYCLES(6)) u_d6 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(ia[0]),
        .in_b(ib[0]), .in_signed(isg[0]), .out_valid(ov[0]), .out_ready(ord[0]),
        .out_c(oc[0]), .busy(bsy[0])
    );

    sync_mul_pipe #(.WIDTH(32), .SETTLE_CYCLES(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(ia[1]),
        .in_b(ib[1]), .in_signed(isg[1]), .out_valid(ov[1]), .out_ready(ord[1]),
        .out_c(oc[1]), .busy(bsy[1])
    );

    function automatic logic [63:0] refmul(logic [31:0] a, logic [31:0] b, logic s);
        if (s) return longint'($signed(a)) * longint'($signed(b));
        return {32'h0, a} * {32'h0, b};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        int s;
        bit rdy;
        for (int d = 0; d < 2; d++) begin
            s = (d == 0) ? 6 : 1;
            if (rst) begin
                m_have[d] = 1'b0;
                m_val[d]  = 1'b0;
                m_c[d]    = '0;
            end else begin
                rdy = !m_have[d] || (m_val[d] && ord[d]);
                if (m_have[d] && !m_val[d] && cyc == m_due[d]) begin
                    m_val[d] = 1'b1;
                    m_c[d]   = m_prod[d];
                end else if (m_val[d] && ord[d]) begin
                    m_val[d]  = 1'b0;
                    m_have[d] = 1'b0;
                end
                if (iv[d] && rdy) begin
                    m_have[d] = 1'b1;
                    m_due[d]  = cyc + s;
                    m_prod[d] = refmul(ia[d], ib[d], isg[d]);
                end
            end
        end
        cyc++;
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d out_valid", d), 64'(ov[d]), 64'(m_val[d]));
                chk($sformatf("d%0d busy", d), 64'(bsy[d]), 64'(m_have[d]));
                chk($sformatf("d%0d in_ready", d), 64'(ir[d]),
                    64'(!m_have[d] || (m_val[d] && ord[d])));
                chk($sformatf("d%0d out_c", d), oc[d], m_c[d]);
            end
        end
        if (ov[1] === 1'b1) begin
            q_val.push_back(oc[1]);
            q_cyc.push_back(cyc);
        end
    end

    // drive a request and return just after the edge that accepted it
    task automatic req(int d, logic [31:0] a, logic [31:0] b, logic s);
        bit ok = 1'b0;
        bit r;
        @(negedge clk); #1;
        iv[d] = 1'b1; ia[d] = a; ib[d] = b; isg[d] = s;
        for (int i = 0; i < 100; i++) begin
            r = ir[d];
            @(posedge clk);
            if (r) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
        #1;
        iv[d] = 1'b0;
        ia[d] = $urandom; ib[d] = $urandom; isg[d] = 1'($urandom);
        chk("accept timeout", 64'(ok), 64'd1);
    endtask

    task automatic get(int d, int lat_exp, logic [63:0] exp, string nm, bit consume);
        int n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (ov[d]) begin n = i; break; end
        end
        chk({nm, " latency"}, 64'(n), 64'(lat_exp));
        chk(nm, oc[d], exp);
        if (consume) begin
            ord[d] = 1'b1;
            @(posedge clk); #1;
            ord[d] = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish by 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        int ops[3] = '{9, 10, 11};
        int idx;
        bit r;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; isg[d] = 1'b0; ia[d] = '0; ib[d] = '0;
        end
        ord[0] = 1'b0;
        ord[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset out_valid", 64'(ov[d]), 64'd0);
            chk("reset out_c", oc[d], 64'd0);
            chk("reset busy", 64'(bsy[d]), 64'd0);
            chk("reset in_ready", 64'(ir[d]), 64'd1);
        end
        rst = 1'b0;

        req(0, 32'hFFFF_FFFD, 32'd5, 1'b1);
        get(0, 6, 64'hFFFF_FFFF_FFFF_FFF1, "s -3*5", 1'b1);
        req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        get(0, 6, 64'hFFFF_FFFE_0000_0001, "u ff*ff", 1'b1);
        req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        get(0, 6, 64'h0000_0000_0000_0001, "s -1*-1", 1'b1);
        req(0, 32'h8000_0000, 32'h8000_0000, 1'b1);
        get(0, 6, 64'h4000_0000_0000_0000, "s min*min", 1'b1);
        req(0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        get(0, 6, 64'h4000_0000_0000_0000, "u 2^31*2^31", 1'b1);
        req(0, 32'h8000_0000, 32'd1, 1'b1);
        get(0, 6, 64'hFFFF_FFFF_8000_0000, "s min*1", 1'b1);

        // back-pressure, then consume and accept on the same edge
        req(0, 32'd2, 32'd3, 1'b0);
        get(0, 6, 64'd6, "bp first", 1'b0);
        repeat (20) begin
            @(negedge clk); #1;
            chk("bp out_valid held", 64'(ov[0]), 64'd1);
            chk("bp out_c held", oc[0], 64'd6);
            chk("bp in_ready low", 64'(ir[0]), 64'd0);
        end
        iv[0] = 1'b1; ia[0] = 32'd4; ib[0] = 32'd5; isg[0] = 1'b0; ord[0] = 1'b1;
        #1;
        chk("bp pulse in_ready", 64'(ir[0]), 64'd1);
        @(posedge clk); #1;
        iv[0] = 1'b0; ord[0] = 1'b0;
        chk("bp consumed", 64'(ov[0]), 64'd0);
        get(0, 6, 64'd20, "bp second", 1'b1);

        // reset while waiting with counter at 3
        req(0, 32'd7, 32'd7, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst-wait out_valid", 64'(ov[0]), 64'd0);
        chk("rst-wait out_c", oc[0], 64'd0);
        chk("rst-wait busy", 64'(bsy[0]), 64'd0);
        chk("rst-wait in_ready", 64'(ir[0]), 64'd1);
        repeat (12) begin
            @(negedge clk);
            chk("rst-wait no stale product", 64'(ov[0]), 64'd0);
        end

        // SETTLE_CYCLES=1 streaming with out_ready tied high
        q_val.delete();
        q_cyc.delete();
        @(negedge clk); #1;
        idx = 0;
        iv[1] = 1'b1; ia[1] = 32'd7; ib[1] = 32'(ops[0]); isg[1] = 1'b0;
        for (int i = 0; i < 50; i++) begin
            r = ir[1];
            @(posedge clk); #1;
            if (r) begin
                idx++;
                if (idx == 3) break;
                ib[1] = 32'(ops[idx]);
            end
        end
        iv[1] = 1'b0;
        repeat (8) @(posedge clk);
        chk("s1 pulse count", 64'(q_val.size()), 64'd3);
        if (q_val.size() >= 3) begin
            chk("s1 7*9", q_val[0], 64'd63);
            chk("s1 7*10", q_val[1], 64'd70);
            chk("s1 7*11", q_val[2], 64'd77);
            chk("s1 spacing 1", 64'(q_cyc[1] - q_cyc[0]), 64'd2);
            chk("s1 spacing 2", 64'(q_cyc[2] - q_cyc[1]), 64'd2);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
